// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//   Program-counter unit for the MIPS31 core. It owns the PC and EPC
//   registers and selects the next PC on every falling clock edge. The
//   sources, highest priority first, are: exception entry, ERET return,
//   jump, taken branch, a previously captured redirect, and the sequential
//   increment. A redirect that arrives while fetch cannot advance is held in
//   a pending slot, so it is never lost.
//
// Ports
//   clk              clock; all state updates happen on the falling edge
//   rst              asynchronous active-high reset
//   ena              global enable; 0 freezes all state and drops requests
//   stall            pipeline stall request from the hazard logic
//   imem_ready       instruction memory accepts the current fetch
//   br_taken         conditional branch resolved taken
//   br_target        branch target address
//   jmp              unconditional jump (j/jal/jr)
//   jmp_target       jump target address
//   exc_req          exception/interrupt request
//   eret             return from exception
//   pc_out           current PC, drives the IMEM address
//   pc_plus          pc_out + STEP (link address)
//   epc_out          saved exception PC
//   fetch_valid      pc_out is a valid fetch request
//   redirect_pending a captured redirect is waiting to be applied
// ---------------------------------------------------------------------------
module pc_next_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0040_0004,
    parameter int          STEP      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc_out,
    output logic             fetch_valid,
    output logic             redirect_pending
);

    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_V  = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    // Redirect targets are word aligned: the two low bits are dropped.
    function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] epc_r;
    logic             pend_valid_r;
    logic [WIDTH-1:0] pend_target_r;

    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] epc_nxt_s;
    logic             pend_valid_nxt_s;
    logic [WIDTH-1:0] pend_target_nxt_s;
    logic             adv_s;

    assign adv_s = ena & ~stall & imem_ready;

    // Next-state selection in priority order; holding is the default.
    always_comb begin
        pc_nxt_s          = pc_r;
        epc_nxt_s         = epc_r;
        pend_valid_nxt_s  = pend_valid_r;
        pend_target_nxt_s = pend_target_r;
        if (ena) begin
            if (exc_req) begin
                epc_nxt_s        = pc_r;
                pc_nxt_s         = EXC_V;
                pend_valid_nxt_s = 1'b0;
            end else if (eret) begin
                pc_nxt_s         = epc_r;
                pend_valid_nxt_s = 1'b0;
            end else if (jmp) begin
                // jmp outranks br_taken; a simultaneous branch is discarded.
                if (adv_s) begin
                    pc_nxt_s         = align_word(jmp_target);
                    pend_valid_nxt_s = 1'b0;
                end else begin
                    pend_target_nxt_s = align_word(jmp_target);
                    pend_valid_nxt_s  = 1'b1;
                end
            end else if (br_taken) begin
                if (adv_s) begin
                    pc_nxt_s         = align_word(br_target);
                    pend_valid_nxt_s = 1'b0;
                end else begin
                    pend_target_nxt_s = align_word(br_target);
                    pend_valid_nxt_s  = 1'b1;
                end
            end else if (pend_valid_r && adv_s) begin
                pc_nxt_s         = pend_target_r;
                pend_valid_nxt_s = 1'b0;
            end else if (adv_s) begin
                pc_nxt_s = pc_r + STEP_V;
            end else begin
                pc_nxt_s = pc_r;
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC, EPC and pending-redirect state, updated on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RST_V;
            epc_r         <= {WIDTH{1'b0}};
            pend_valid_r  <= 1'b0;
            pend_target_r <= {WIDTH{1'b0}};
        end else begin
            pc_r          <= pc_nxt_s;
            epc_r         <= epc_nxt_s;
            pend_valid_r  <= pend_valid_nxt_s;
            pend_target_r <= pend_target_nxt_s;
        end
    end

    // While rst is high the IMEM address is pinned to the reset vector
    // without waiting for a clock edge.
    always_comb begin
        if (rst) begin
            pc_out = RST_V;
        end else begin
            pc_out = pc_r;
        end
    end

    assign pc_plus          = pc_out + STEP_V;
    assign epc_out          = epc_r;
    assign redirect_pending = pend_valid_r;
    assign fetch_valid      = ~rst & ena & ~stall;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        stall;
    logic        imem_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic [31:0] epc_out;
    logic        fetch_valid;
    logic        redirect_pending;

    int n_checks = 0;
    int n_fail   = 0;

    pc_next_unit #(
        .WIDTH     (32),
        .RESET_VEC (32'h0040_0000),
        .EXC_VEC   (32'h0040_0004),
        .STEP      (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp              (jmp),
        .jmp_target       (jmp_target),
        .exc_req          (exc_req),
        .eret             (eret),
        .pc_out           (pc_out),
        .pc_plus          (pc_plus),
        .epc_out          (epc_out),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        br_taken = 1'b0; br_target = 32'h0; jmp = 1'b0; jmp_target = 32'h0;
        exc_req = 1'b0; eret = 1'b0;
        #2 rst = 1'b1;
        #2;
        n_checks++; if (pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", pc_out, 32'h0040_0000); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_valid: got %b expected 0", fetch_valid); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b expected 0", redirect_pending); end
        n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL rst_epc: got %h expected 0", epc_out); end
        @(posedge clk); #3;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_checks++; if (pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL rel_pc: got %h expected %h", pc_out, 32'h0040_0000); end
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rel_fetch_valid: got %b expected 1", fetch_valid); end
    endtask

    task automatic test_sequential();
        tick();
        n_checks++; if (pc_out !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc1: got %h expected %h", pc_out, 32'h0040_0004); end
        n_checks++; if (pc_plus !== 32'h0040_0008) begin n_fail++; $display("FAIL seq_plus1: got %h expected %h", pc_plus, 32'h0040_0008); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0008) begin n_fail++; $display("FAIL seq_pc2: got %h expected %h", pc_out, 32'h0040_0008); end
        imem_ready = 1'b0;
        tick();
        n_checks++; if (pc_out !== 32'h0040_0008) begin n_fail++; $display("FAIL notready_hold: got %h expected %h", pc_out, 32'h0040_0008); end
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL notready_fv: got %b expected 1", fetch_valid); end
        imem_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (pc_out !== 32'h0040_0010) begin n_fail++; $display("FAIL seq_pc4: got %h expected %h", pc_out, 32'h0040_0010); end
    endtask

    task automatic test_jump_stalled();
        stall = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_0103;
        tick();
        jmp = 1'b0; stall = 1'b0;
        n_checks++; if (pc_out !== 32'h0040_0010) begin n_fail++; $display("FAIL jst_hold: got %h expected %h", pc_out, 32'h0040_0010); end
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL jst_pending: got %b expected 1", redirect_pending); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0100) begin n_fail++; $display("FAIL jst_apply: got %h expected %h", pc_out, 32'h0040_0100); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL jst_clear: got %b expected 0", redirect_pending); end
    endtask

    task automatic test_exc_eret();
        jmp = 1'b1; jmp_target = 32'h0040_0020;
        tick();
        n_checks++; if (pc_out !== 32'h0040_0020) begin n_fail++; $display("FAIL exc_setup: got %h expected %h", pc_out, 32'h0040_0020); end
        stall = 1'b1; jmp_target = 32'h0040_0500;
        tick();
        jmp = 1'b0; exc_req = 1'b1;
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL exc_prepend: got %b expected 1", redirect_pending); end
        tick();
        exc_req = 1'b0; stall = 1'b0;
        n_checks++; if (pc_out !== 32'h0040_0004) begin n_fail++; $display("FAIL exc_pc: got %h expected %h", pc_out, 32'h0040_0004); end
        n_checks++; if (epc_out !== 32'h0040_0020) begin n_fail++; $display("FAIL exc_epc: got %h expected %h", epc_out, 32'h0040_0020); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL exc_pend_clr: got %b expected 0", redirect_pending); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0008) begin n_fail++; $display("FAIL exc_handler_seq: got %h expected %h", pc_out, 32'h0040_0008); end
        stall = 1'b1; eret = 1'b1;
        tick();
        stall = 1'b0; eret = 1'b0;
        n_checks++; if (pc_out !== 32'h0040_0020) begin n_fail++; $display("FAIL eret_pc: got %h expected %h", pc_out, 32'h0040_0020); end
    endtask

    task automatic test_priority();
        jmp = 1'b1; jmp_target = 32'h0040_0200;
        br_taken = 1'b1; br_target = 32'h0040_0300;
        tick();
        jmp = 1'b0;
        n_checks++; if (pc_out !== 32'h0040_0200) begin n_fail++; $display("FAIL prio_jmp: got %h expected %h", pc_out, 32'h0040_0200); end
        br_target = 32'h0040_0312;
        tick();
        n_checks++; if (pc_out !== 32'h0040_0310) begin n_fail++; $display("FAIL br_align: got %h expected %h", pc_out, 32'h0040_0310); end
        stall = 1'b1; br_target = 32'h0040_0300;
        tick();
        br_taken = 1'b0; jmp = 1'b1; jmp_target = 32'h0040_0407;
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL ovw_pend: got %b expected 1", redirect_pending); end
        tick();
        jmp = 1'b0; stall = 1'b0;
        n_checks++; if (pc_out !== 32'h0040_0310) begin n_fail++; $display("FAIL ovw_hold: got %h expected %h", pc_out, 32'h0040_0310); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0404) begin n_fail++; $display("FAIL ovw_newest: got %h expected %h", pc_out, 32'h0040_0404); end
    endtask

    task automatic test_wrap_enable();
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick();
        jmp = 1'b0;
        n_checks++; if (pc_plus !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_plus: got %h expected %h", pc_plus, 32'h0); end
        tick();
        n_checks++; if (pc_out !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc_out, 32'h0); end
        ena = 1'b0; exc_req = 1'b1;
        tick();
        n_checks++; if (pc_out !== 32'h0000_0000) begin n_fail++; $display("FAIL ena0_pc: got %h expected %h", pc_out, 32'h0); end
        n_checks++; if (epc_out !== 32'h0040_0020) begin n_fail++; $display("FAIL ena0_epc: got %h expected %h", epc_out, 32'h0040_0020); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL ena0_fv: got %b expected 0", fetch_valid); end
        ena = 1'b1; exc_req = 1'b0;
    endtask

    task automatic test_async_reset_pending();
        stall = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_0600;
        tick();
        jmp = 1'b0;
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got %b expected 1", redirect_pending); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL arst_pc: got %h expected %h", pc_out, 32'h0040_0000); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL arst_pend: got %b expected 0", redirect_pending); end
        n_checks++; if (epc_out !== 32'h0) begin n_fail++; $display("FAIL arst_epc: got %h expected 0", epc_out); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL arst_fv: got %b expected 0", fetch_valid); end
        #1 rst = 1'b0; stall = 1'b0;
        tick();
        n_checks++; if (pc_out !== 32'h0040_0004) begin n_fail++; $display("FAIL arst_restart: got %h expected %h", pc_out, 32'h0040_0004); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_stalled();
        test_exc_eret();
        test_priority();
        test_wrap_enable();
        test_async_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter unit for the MIPS31 core.
- Owns the PC register and selects the next PC from:
  - sequential increment
  - jump and branch redirects
  - exception entry and ERET return
- Holds an EPC register.
- Latches a redirect that arrives while fetch is stalled, so no redirect is lost.
- Sits between the control/branch logic and instruction memory; its output drives the IMEM address.

Parameters:
- WIDTH, 32, PC/EPC/target width in bits (>= 8).
- RESET_VEC, 32'h0040_0000, PC value on reset (truncated to WIDTH).
- EXC_VEC, 32'h0040_0004, exception handler entry address (truncated to WIDTH).
- STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock; all state updates on falling edge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  global enable; 0 freezes all state.
- stall  in  1  pipeline stall request from hazard logic.
- imem_ready  in  1  instruction memory accepts the current fetch.
- br_taken  in  1  conditional branch resolved taken.
- br_target  in  WIDTH  branch target.
- jmp  in  1  unconditional jump (j/jal/jr).
- jmp_target  in  WIDTH  jump target.
- exc_req  in  1  exception/interrupt request.
- eret  in  1  return from exception.
- pc_out  out  WIDTH  current PC / IMEM address.
- pc_plus  out  WIDTH  pc_out + STEP (link address).
- epc_out  out  WIDTH  saved exception PC.
- fetch_valid  out  1  current pc_out is a valid fetch request.
- redirect_pending  out  1  a captured redirect awaits application.

Behaviour:
- Reset (async, rst=1):
  - pc <= RESET_VEC, epc <= 0, pend_valid <= 0, pend_target <= 0.
  - While rst=1, pc_out is forced combinationally to RESET_VEC and fetch_valid=0.
- Advance condition: adv = ena & ~stall & imem_ready.
- ena=0: no register changes. Requests presented that edge are dropped, including exc_req and eret.
- Priority per falling edge with ena=1, highest first:
  1. exc_req: epc <= pc, pc <= EXC_VEC, pend_valid <= 0. Applies regardless of stall/imem_ready.
  2. eret: pc <= epc, pend_valid <= 0. Applies regardless of stall/imem_ready.
  3. jmp:
     - If adv: pc <= jmp_target, pend_valid <= 0.
     - Else: pend_target <= jmp_target, pend_valid <= 1.
  4. br_taken: same rules as jmp, using br_target.
  5. pend_valid & adv: pc <= pend_target, pend_valid <= 0.
  6. adv: pc <= pc + STEP.
  7. Otherwise: hold.
- jmp and br_taken together: jmp wins and the branch is discarded.
- A new redirect while pend_valid=1 and not adv overwrites pend_target (newest wins).
- Arithmetic:
  - pc + STEP wraps modulo 2^WIDTH; no carry out (e.g. WIDTH=32, pc=FFFF_FFFC -> 0000_0000).
  - Bits [1:0] of every target written into pc or pend_target are forced to 00. EXC_VEC and RESET_VEC are used as-is.
- Outputs:
  - pc_out = pc (RESET_VEC during rst).
  - pc_plus = pc_out + STEP.
  - epc_out = epc.
  - redirect_pending = pend_valid.
  - fetch_valid = ~rst & ena & ~stall.
- Latency:
  - A redirect applied under adv is visible on pc_out immediately after that falling edge.
  - A captured redirect appears one edge after adv becomes 1.
- Reset mid-operation: a pending redirect and the EPC are discarded; fetch restarts at RESET_VEC.

Test Plan:
- Reset and sequential fetch: release rst with ena=1, stall=0, imem_ready=1 -> pc_out 0040_0000, 0040_0004, 0040_0008 on successive falling edges; pc_plus = pc_out+4.
- Jump while stalled: pc=0040_0010, stall=1, jmp=1, jmp_target=0040_0103 for one edge, then stall=0 -> redirect_pending=1 and pc holds 0040_0010; next edge pc=0040_0100, pending cleared.
- Exception/ERET round trip: pc=0040_0020 with stall=1, exc_req=1 -> pc=0040_0004, epc_out=0040_0020; later eret=1 -> pc=0040_0020.
- Priority and overwrite:
  - jmp and br_taken together (targets 0040_0200 / 0040_0300) with adv -> pc=0040_0200.
  - While stalled, br then jmp on consecutive edges -> pending target is the jmp target.
- Wrap and enable: WIDTH=32, pc=FFFF_FFFC, adv -> pc=0000_0000; with ena=0 and exc_req=1 -> pc and epc unchanged.
- Async reset mid-pending: assert rst between edges while redirect_pending=1 -> pc_out=0040_0000 immediately, redirect_pending=0, epc_out=0.
